fp_mul_operand_sequencer: RTL and testbench
===========================================

// Module: fp_mul_operand_sequencer
// PURPOSE
//  Upstream feeder for the IEEE-754 single-precision multiplier core (start/A/B in, result/overflow_flag out).
//  Buffers operand pairs in a small FIFO (valid/ready in) and launches one multiply at a time.
//  Holds A/B stable for the whole operation and waits a fixed latency.
//  Captures the result and overflow flag and presents them on a valid/ready output.
//  Counts overflowed results.
// PARAMETERS
//  DEPTH        4  operand FIFO entries; power of 2, >=2
//  MUL_LATENCY  6  cycles from the edge sampling mul_start=1 to a stable mul_result; >=1
//  CNT_W        8  width of saturating overflow counter
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-low (0 = reset asserted)
//  in_valid      in   1      operand pair offered
//  in_ready      out  1      FIFO can accept (= !full)
//  in_a          in   32     operand A, IEEE-754 single
//  in_b          in   32     operand B, IEEE-754 single
//  mul_start     out  1      one-cycle launch pulse to multiplier
//  mul_a         out  32     registered operand A to multiplier
//  mul_b         out  32     registered operand B to multiplier
//  mul_result    in   32     multiplier result
//  mul_overflow  in   1      multiplier overflow_flag
//  out_valid     out  1      captured result available
//  out_ready     in   1      consumer accepts result
//  out_result    out  32     captured product
//  out_overflow  out  1      captured overflow flag
//  ovf_count     out  CNT_W  number of results with overflow; saturates at all-ones
//  busy          out  1      state != IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (reset=0, async): FIFO pointers/count=0; state=IDLE; wait counter=0.
//   All outputs are 0, except in_ready=1 once reset is released.
//  Reset mid-operation discards FIFO contents and any in-flight result. No mul_start is issued afterwards.
//  FIFO: push when in_valid&&in_ready; pop on the capture edge.
//   Pointers wrap modulo DEPTH. Push and pop in the same edge leave the count unchanged.
//   There is no write-through when full.
//  FSM:
//   IDLE:   FIFO non-empty -> load mul_a/mul_b from the head; go to LAUNCH.
//   LAUNCH: mul_start=1 for exactly this cycle; cnt<=MUL_LATENCY-1; go to WAIT.
//   WAIT:   cnt!=0 -> cnt-1.
//           cnt==0 -> capture mul_result/mul_overflow into out_*; pop; out_valid<=1; go to HOLD.
//   HOLD:   out_valid=1 and out_* stable until out_ready.
//           On out_ready: out_valid<=0.
//           If FIFO non-empty (count after any same-edge push), load the next head and go to LAUNCH; else go to IDLE.
//  mul_a/mul_b change only on the load edge. They are held through LAUNCH, WAIT and HOLD.
//  Latency: the accepting edge of a pair into an empty idle block is E0.
//   mul_start is high after E1. out_valid rises after edge E(MUL_LATENCY+2).
//  Throughput: one result per MUL_LATENCY+2 cycles when out_ready is held at 1.
//  ovf_count increments on each capture with mul_overflow=1. It holds at 2^CNT_W-1.
//  Results are delivered in the order the operands were accepted. No reordering and no drops.
// TESTING
//  Use a bench multiplier model that returns the IEEE product exactly MUL_LATENCY cycles after start.
//  1. Single op: A=0x3FC00000, B=0x40000000 -> out_result=0x40400000, out_overflow=0.
//     out_valid rises 8 cycles after accept (MUL_LATENCY=6); exactly one mul_start pulse.
//  2. Overflow: A=B=0x7F000000 -> out_overflow=1, ovf_count=1.
//     Repeat 260 times with CNT_W=8 -> ovf_count=255.
//  3. Fill: 5 pairs offered back-to-back with out_ready=0 -> in_ready drops after 4 accepts (DEPTH=4).
//     Results then come out in order 1..5 as out_ready is asserted.
//  4. Backpressure: hold out_ready=0 for 20 cycles -> out_result/out_valid stable.
//     No new mul_start; mul_a/mul_b unchanged.
//  5. Streaming: 8 pairs with out_ready=1 -> mul_start every 8 cycles.
//     Pointer wrap is exercised; all 8 products are correct and in order.
//  6. Reset pulse (reset=0) during WAIT -> all outputs 0 asynchronously.
//     After release, a new pair A=0x40400000, B=0x3F000000 yields 0x3FC00000.

Source files
------------

// File: rtl/fp_mul_operand_sequencer.sv
// Operand sequencer for a fixed-latency FP32 multiplier: buffers operand pairs, launches one
// multiply at a time, captures result/overflow into a valid/ready output and counts overflows.
module fp_mul_operand_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned MUL_LATENCY = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             mul_start,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_result,
    input  logic             mul_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);
    localparam int unsigned LAT_W  = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StHold} state_e;

    state_e            state;
    logic [31:0]       mem_a [DEPTH];
    logic [31:0]       mem_b [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_after_push;
    logic [LAT_W-1:0]  wait_cnt;
    logic              push;
    logic              pop;
    logic [31:0]       head_a;
    logic [31:0]       head_b;

    assign in_ready        = reset && (fill != FILL_W'(DEPTH));
    assign push            = in_valid && in_ready;
    assign pop             = (state == StWait) && (wait_cnt == '0);
    assign fill_after_push = fill + FILL_W'(push);
    assign busy            = (state != StIdle) || (fill != '0);

    // An empty FIFO being written on this edge presents the incoming pair as its head.
    assign head_a = (fill == '0) ? in_a : mem_a[rd_ptr];
    assign head_b = (fill == '0) ? in_b : mem_b[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fill <= fill + FILL_W'(push) - FILL_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= StIdle;
            wait_cnt     <= '0;
            mul_start    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            ovf_count    <= '0;
        end else begin
            mul_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (fill != '0) begin
                        mul_a     <= head_a;
                        mul_b     <= head_b;
                        mul_start <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    wait_cnt <= LAT_W'(MUL_LATENCY - 1);
                    state    <= StWait;
                end
                StWait: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - LAT_W'(1);
                    end else begin
                        out_result   <= mul_result;
                        out_overflow <= mul_overflow;
                        out_valid    <= 1'b1;
                        if (mul_overflow && (ovf_count != '1)) begin
                            ovf_count <= ovf_count + CNT_W'(1);
                        end
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (fill_after_push != '0) begin
                            mul_a     <= head_a;
                            mul_b     <= head_b;
                            mul_start <= 1'b1;
                            state     <= StLaunch;
                        end else begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_operand_sequencer.sv
// Directed bench for fp_mul_operand_sequencer with a fixed-latency multiplier model that
// returns table products (or A=1.0 pass-through) MUL_LATENCY cycles after mul_start.
module tb_fp_mul_operand_sequencer;

    localparam int unsigned DEPTH       = 4;
    localparam int unsigned MUL_LATENCY = 6;
    localparam int unsigned CNT_W       = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic             mul_start;
    logic [31:0]      mul_a;
    logic [31:0]      mul_b;
    logic [31:0]      mul_result;
    logic             mul_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic             out_overflow;
    logic [CNT_W-1:0] ovf_count;
    logic             busy;

    fp_mul_operand_sequencer #(
        .DEPTH(DEPTH),
        .MUL_LATENCY(MUL_LATENCY),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .mul_start(mul_start),
        .mul_a(mul_a),
        .mul_b(mul_b),
        .mul_result(mul_result),
        .mul_overflow(mul_overflow),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_overflow(out_overflow),
        .ovf_count(ovf_count),
        .busy(busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] ints [8];

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_start = 0;
    int          start_cyc [$];
    logic [32:0] got_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Samples just before each rising edge, when everything is settled.
    always begin
        @(negedge clk);
        #4;
        if (mul_start === 1'b1) begin
            n_start++;
            start_cyc.push_back(cyc);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got_q.push_back({out_overflow, out_result});
        end
    end

    function automatic logic [32:0] mdl_mul(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].a == a && vecs[i].b == b) return {vecs[i].ovf, vecs[i].res};
        end
        if (a == 32'h3F80_0000) return {1'b0, b};
        return {1'b1, 32'hDEAD_BEEF};
    endfunction

    // Multiplier model: garbage with overflow set until the product becomes valid.
    int          mdl_cnt = 0;
    logic        mdl_busy = 1'b0;
    logic [32:0] mdl_pend = '0;
    initial begin
        mul_result   = '0;
        mul_overflow = 1'b0;
    end
    always @(posedge clk) begin
        if (mul_start === 1'b1) begin
            mdl_pend     <= mdl_mul(mul_a, mul_b);
            mdl_cnt      <= MUL_LATENCY - 1;
            mdl_busy     <= 1'b1;
            mul_result   <= 32'hDEAD_BEEF;
            mul_overflow <= 1'b1;
        end else if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                {mul_overflow, mul_result} <= mdl_pend;
                mdl_busy <= 1'b0;
            end
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out", name);
    endtask

    // Call on a falling edge; returns on the falling edge after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok       = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) fail_now("send");
    endtask

    task automatic wait_results(input int n, input int budget);
        int i;
        i = 0;
        while (got_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("result_count", got_q.size(), n);
    endtask

    task automatic expect_result(input string name, input logic [31:0] res, input logic ovf);
        logic [32:0] g;
        if (got_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no result, expected %0h", name, res);
            return;
        end
        g = got_q.pop_front();
        check({name, "_res"}, g[31:0], res);
        check({name, "_ovf"}, g[32], ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          exp_cnt;
        int          n_acc;
        int          bad;
        int          w;
        bit          ok;
        logic [32:0] last;

        vecs[0] = '{a: 32'h3FC0_0000, b: 32'h4000_0000, res: 32'h4040_0000, ovf: 1'b0};
        vecs[1] = '{a: 32'h7F00_0000, b: 32'h7F00_0000, res: 32'h7F80_0000, ovf: 1'b1};
        vecs[2] = '{a: 32'h4040_0000, b: 32'h3F00_0000, res: 32'h3FC0_0000, ovf: 1'b0};
        vecs[3] = '{a: 32'hC000_0000, b: 32'h4040_0000, res: 32'hC0C0_0000, ovf: 1'b0};
        vecs[4] = '{a: 32'hBF80_0000, b: 32'h40A0_0000, res: 32'hC0A0_0000, ovf: 1'b0};
        vecs[5] = '{a: 32'h0000_0000, b: 32'h4000_0000, res: 32'h0000_0000, ovf: 1'b0};
        vecs[6] = '{a: 32'h7F7F_FFFF, b: 32'h4000_0000, res: 32'h7F80_0000, ovf: 1'b1};
        ints = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000,
                 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
        last = '0;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_flags", {in_ready, mul_start, out_valid, out_overflow, busy}, 0);
        check("rst_mul_ab", {mul_a, mul_b}, 0);
        check("rst_out_result", out_result, 0);
        check("rst_ovf_count", ovf_count, 0);
        reset = 1'b1;
        #1;
        check("rst_in_ready_release", in_ready, 1);
        @(negedge clk);

        // Single op latency and pulse count
        n_start  = 0;
        in_a     = vecs[0].a;
        in_b     = vecs[0].b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("t1_latency", lat, MUL_LATENCY + 2);
        check("t1_out_result", out_result, 32'h4040_0000);
        check("t1_out_overflow", out_overflow, 0);
        check("t1_start_pulses", n_start, 1);
        out_ready = 1'b1;
        wait_results(1, 10);
        expect_result("t1", 32'h4040_0000, 1'b0);

        // Table of single operations
        exp_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b);
            wait_results(1, 40);
            expect_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].ovf);
            if (vecs[i].ovf) exp_cnt++;
            check($sformatf("vec%0d_ovf_count", i), ovf_count, exp_cnt);
        end

        // Overflow counter saturation
        for (int k = 0; k < 260; k++) begin
            send(vecs[1].a, vecs[1].b);
            w = 0;
            while (got_q.size() == 0 && w < 40) begin
                @(negedge clk);
                w++;
            end
            if (got_q.size() == 0) begin
                fail_now("t2_result_wait");
                break;
            end
            last = got_q.pop_front();
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
        check("t2_last_result", last[31:0], vecs[1].res);
        check("t2_last_ovf", last[32], 1);
        check("t2_ovf_count_sat", ovf_count, exp_cnt);

        // Fill the FIFO with out_ready low
        out_ready = 1'b0;
        n_acc     = 0;
        in_a      = 32'h3F80_0000;
        in_b      = ints[0];
        in_valid  = 1'b1;
        for (int i = 0; i < 10 && n_acc < 4; i++) begin
            if (in_ready === 1'b1) n_acc++;
            @(posedge clk);
            @(negedge clk);
            in_b = ints[n_acc];
        end
        check("t3_accepts", n_acc, 4);
        check("t3_in_ready_full", in_ready, 0);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t3_fifth_accepted", ok, 1);
        check("t3_nothing_delivered", got_q.size(), 0);
        out_ready = 1'b1;
        wait_results(5, 120);
        for (int k = 0; k < 5; k++) expect_result($sformatf("t3_order%0d", k), ints[k], 1'b0);

        // Backpressure: result and operands held, no relaunch
        out_ready = 1'b0;
        n_start   = 0;
        send(vecs[3].a, vecs[3].b);
        send(32'h3F80_0000, ints[6]);
        w = 0;
        while (out_valid !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== vecs[3].res || mul_a !== vecs[3].a ||
                mul_b !== vecs[3].b || mul_start !== 1'b0) bad++;
        end
        check("t4_unstable_cycles", bad, 0);
        check("t4_out_result", out_result, vecs[3].res);
        check("t4_mul_a", mul_a, vecs[3].a);
        check("t4_mul_b", mul_b, vecs[3].b);
        check("t4_start_pulses", n_start, 1);
        out_ready = 1'b1;
        wait_results(2, 60);
        expect_result("t4_first", vecs[3].res, 1'b0);
        expect_result("t4_second", ints[6], 1'b0);

        // Streaming with pointer wrap
        start_cyc.delete();
        for (int k = 0; k < 8; k++) send(32'h3F80_0000, ints[k]);
        wait_results(8, 200);
        for (int k = 0; k < 8; k++) expect_result($sformatf("t5_order%0d", k), ints[k], 1'b0);
        check("t5_start_count", start_cyc.size(), 8);
        for (int k = 1; k < 8 && k < start_cyc.size(); k++) begin
            check($sformatf("t5_start_gap%0d", k), start_cyc[k] - start_cyc[k-1],
                  MUL_LATENCY + 2);
        end

        // Reset during WAIT
        send(vecs[0].a, vecs[0].b);
        send(32'h3F80_0000, ints[1]);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_flags", {in_ready, mul_start, out_valid, out_overflow, busy}, 0);
        check("t6_mul_ab", {mul_a, mul_b}, 0);
        check("t6_out_result", out_result, 0);
        check("t6_ovf_count", ovf_count, 0);
        @(negedge clk);
        got_q.delete();
        n_start = 0;
        reset   = 1'b1;
        repeat (20) @(negedge clk);
        check("t6_no_start_after_reset", n_start, 0);
        check("t6_no_result_after_reset", got_q.size(), 0);
        check("t6_idle", busy, 0);
        send(32'h4040_0000, 32'h3F00_0000);
        wait_results(1, 40);
        expect_result("t6_after", 32'h3FC0_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
